// File: rtl/alu_ctrl_pkg.sv
// Shared types for the accumulator-datapath sequencer:
// opcode enums, FSM states, IR field positions, decode bundle.
package alu_ctrl_pkg;

  localparam int IR_W     = 9;
  localparam int IR_TYPE  = 8;
  localparam int ROP_HI   = 7;
  localparam int ROP_LO   = 4;
  localparam int IOP_HI   = 7;
  localparam int IOP_LO   = 5;
  localparam int IMM_HI   = 4;
  localparam int IMM_LO   = 0;

  typedef enum logic [3:0] {
    R_ADD = 4'b0000,
    R_SUB = 4'b0001,
    R_AND = 4'b0010,
    R_OR  = 4'b0011,
    R_XOR = 4'b0100,
    R_SHL = 4'b0101,
    R_SHR = 4'b0110,
    R_NOT = 4'b0111,
    R_LW  = 4'b1000,
    R_SW  = 4'b1001,
    R_SLT = 4'b1010,
    R_MOV = 4'b1011,
    R_BR  = 4'b1100,
    R_J   = 4'b1101,
    R_SET = 4'b1110,
    R_LA  = 4'b1111
  } rop_e;

  typedef enum logic [2:0] {
    I_ADDI = 3'b000,
    I_SUBI = 3'b001,
    I_ANDI = 3'b010,
    I_ORI  = 3'b011,
    I_SHLI = 3'b100,
    I_SETI = 3'b101,
    I_NOP  = 3'b110,
    I_HALT = 3'b111
  } iop_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_DONE
  } state_e;

  typedef struct packed {
    logic is_alu_wr;
    logic is_set;
    logic is_mem;
    logic mem_we;
    logic is_br;
    logic is_j;
    logic is_halt;
    logic updates_sc;
  } dec_t;

endpackage

// File: rtl/alu_sequencer_decode.sv
// Combinational IR decode into sequencer control classes.
// Bit 8 clear selects R-type, set selects I-type.
module instr_decode
  import alu_ctrl_pkg::*;
(
  input  logic [IR_W-1:0] ir_i,
  output dec_t            dec_o
);

  logic is_i;
  rop_e rop;
  iop_e iop;

  assign is_i = ir_i[IR_TYPE];
  assign rop  = rop_e'(ir_i[ROP_HI:ROP_LO]);
  assign iop  = iop_e'(ir_i[IOP_HI:IOP_LO]);

  always_comb begin
    dec_o = '0;
    if (is_i) begin
      unique case (iop)
        I_NOP:  ;
        I_HALT: dec_o.is_halt = 1'b1;
        default: begin
          dec_o.is_alu_wr  = 1'b1;
          dec_o.updates_sc = (iop == I_ADDI) ||
                             (iop == I_SUBI);
        end
      endcase
    end else begin
      unique case (rop)
        R_LW:  dec_o.is_mem = 1'b1;
        R_SW: begin
          dec_o.is_mem = 1'b1;
          dec_o.mem_we = 1'b1;
        end
        R_BR:  dec_o.is_br  = 1'b1;
        R_J:   dec_o.is_j   = 1'b1;
        R_SET: dec_o.is_set = 1'b1;
        default: begin
          dec_o.is_alu_wr  = 1'b1;
          dec_o.updates_sc = (rop == R_ADD) ||
                             (rop == R_SUB);
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle fetch/exec sequencer for the accumulator ALU.
// Owns PC, IR and shift-carry; strobes are decoded from state.
module alu_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int RF_AW = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic [PC_W-1:0]   instr_addr,
  input  logic [IR_W-1:0]   instr_in,
  output logic              type_code,
  output logic [3:0]        r_op,
  output logic [2:0]        i_op,
  output logic [4:0]        imm,
  output logic [RF_AW-1:0]  reg_idx,
  output logic              sc_in,
  input  logic              alu_sc_out,
  input  logic              alu_branch,
  input  logic [PC_W-1:0]   lut_target,
  output logic              acc_we,
  output logic              acc_sel,
  output logic              reg_we,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic              sc_q, sc_d;
  dec_t              dec;
  logic              in_exec, in_mem, lw_done;

  instr_decode u_dec (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

  assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    sc_d    = sc_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          sc_d    = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = instr_in;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        if (dec.updates_sc) sc_d = alu_sc_out;
        unique case (1'b1)
          dec.is_halt: state_d = S_DONE;
          dec.is_mem: begin
            if (mem_ack) pc_d = pc_inc;
            else state_d = S_MEM;
          end
          dec.is_br: pc_d = alu_branch ? lut_target : pc_inc;
          dec.is_j:  pc_d = lut_target;
          default:   pc_d = pc_inc;
        endcase
      end
      S_MEM: begin
        if (mem_ack) begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      sc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      sc_q    <= sc_d;
    end
  end

  // LW completion may land in EXEC or MEM; mem_ack gates it.
  assign in_exec = (state_q == S_EXEC);
  assign in_mem  = (in_exec && dec.is_mem) ||
                   (state_q == S_MEM);
  assign lw_done = in_mem && !dec.mem_we && mem_ack;

  assign mem_req = in_mem;
  assign mem_we  = in_mem && dec.mem_we;
  assign acc_we  = (in_exec && dec.is_alu_wr) || lw_done;
  assign acc_sel = lw_done;
  assign reg_we  = in_exec && dec.is_set;

  assign busy = (state_q == S_FETCH) ||
                (state_q == S_EXEC)  ||
                (state_q == S_MEM);
  assign done = (state_q == S_DONE);

  assign instr_addr = pc_q;
  assign type_code  = ir_q[IR_TYPE];
  assign r_op       = ir_q[ROP_HI:ROP_LO];
  assign i_op       = ir_q[IOP_HI:IOP_LO];
  assign imm        = ir_q[IMM_HI:IMM_LO];
  assign reg_idx    = ir_q[RF_AW-1:0];
  assign sc_in      = sc_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural ROM.
// strb = {busy,done,acc_we,acc_sel,reg_we,mem_req,mem_we}.
module tb_alu_sequencer;

  localparam logic [8:0] NOP  = 9'h1C0;
  localparam logic [8:0] HALT = 9'h1E0;
  localparam logic [8:0] ADDI5 = 9'h105;
  localparam logic [8:0] ADD1 = 9'h001;
  localparam logic [8:0] AND1 = 9'h021;
  localparam logic [8:0] LW2  = 9'h082;
  localparam logic [8:0] SW2  = 9'h092;
  localparam logic [8:0] BR3  = 9'h0C3;
  localparam logic [8:0] J3   = 9'h0D3;
  localparam logic [8:0] SET1 = 9'h0E1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] instr_addr;
  logic [8:0] instr_in;
  logic       type_code;
  logic [3:0] r_op;
  logic [2:0] i_op;
  logic [4:0] imm;
  logic [3:0] reg_idx;
  logic       sc_in;
  logic       alu_sc_out = 1'b0;
  logic       alu_branch = 1'b0;
  logic [9:0] lut_target = '0;
  logic       acc_we, acc_sel, reg_we;
  logic       mem_req, mem_we;
  logic       mem_ack = 1'b0;
  logic       busy, done;

  logic [8:0] rom [1024];
  int n_cmp = 0;
  int n_bad = 0;

  wire [6:0] strb = {busy, done, acc_we, acc_sel,
                     reg_we, mem_req, mem_we};

  assign instr_in = rom[instr_addr];

  always #5 clk = ~clk;

  alu_sequencer #(.PC_W(10), .RF_AW(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .instr_addr (instr_addr),
    .instr_in   (instr_in),
    .type_code  (type_code),
    .r_op       (r_op),
    .i_op       (i_op),
    .imm        (imm),
    .reg_idx    (reg_idx),
    .sc_in      (sc_in),
    .alu_sc_out (alu_sc_out),
    .alu_branch (alu_branch),
    .lut_target (lut_target),
    .acc_we     (acc_we),
    .acc_sel    (acc_sel),
    .reg_we     (reg_we),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rom;
    for (int i = 0; i < 1024; i++) rom[i] = HALT;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (strb !== 7'b0) begin
      n_bad++;
      $display("FAIL reset_strb got %b want %b", strb, 7'b0);
    end
    n_cmp++;
    if (instr_addr !== 10'd0 || sc_in !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_pc_sc got %h/%b want 000/0",
               instr_addr, sc_in);
    end
    n_cmp++;
    if ({type_code, r_op, imm} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_ir got %b want 0",
               {type_code, r_op, imm});
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (strb !== 7'b0) begin
      n_bad++;
      $display("FAIL idle_strb got %b want 0", strb);
    end
  endtask

  task automatic test_addi_halt;
    fill_rom();
    rom[0] = ADDI5;
    alu_sc_out = 1'b1;
    pulse_start();
    n_cmp++;
    if (strb !== 7'b1000000 || instr_addr !== 10'd0) begin
      n_bad++;
      $display("FAIL addi_fetch got %b/%h want 1000000/000",
               strb, instr_addr);
    end
    tick();
    n_cmp++;
    if (strb !== 7'b1010000) begin
      n_bad++;
      $display("FAIL addi_exec got %b want 1010000", strb);
    end
    n_cmp++;
    if ({type_code, i_op, imm} !== 9'h105) begin
      n_bad++;
      $display("FAIL addi_fields got %h want 105",
               {type_code, i_op, imm});
    end
    tick();
    n_cmp++;
    if (sc_in !== 1'b1 || instr_addr !== 10'd1) begin
      n_bad++;
      $display("FAIL addi_sc got %b/%h want 1/001",
               sc_in, instr_addr);
    end
    alu_sc_out = 1'b0;
    tick();
    n_cmp++;
    if (strb !== 7'b1000000) begin
      n_bad++;
      $display("FAIL halt_exec got %b want 1000000", strb);
    end
    tick();
    n_cmp++;
    if (strb !== 7'b0100000 || instr_addr !== 10'd1) begin
      n_bad++;
      $display("FAIL halt_done got %b/%h want 0100000/001",
               strb, instr_addr);
    end
  endtask

  task automatic test_mem;
    fill_rom();
    rom[0] = LW2;
    rom[1] = SW2;
    pulse_start();
    n_cmp++;
    if (sc_in !== 1'b0) begin
      n_bad++;
      $display("FAIL start_clr_sc got %b want 0", sc_in);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (strb !== 7'b1000010) begin
        n_bad++;
        $display("FAIL lw_wait%0d got %b want 1000010", i, strb);
      end
    end
    tick();
    mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (strb !== 7'b1011010 || instr_addr !== 10'd0) begin
      n_bad++;
      $display("FAIL lw_ack got %b/%h want 1011010/000",
               strb, instr_addr);
    end
    tick();
    mem_ack = 1'b0;
    n_cmp++;
    if (strb !== 7'b1000000 || instr_addr !== 10'd1) begin
      n_bad++;
      $display("FAIL lw_next got %b/%h want 1000000/001",
               strb, instr_addr);
    end
    tick();
    mem_ack = 1'b1;
    #1;
    n_cmp++;
    if (strb !== 7'b1000011) begin
      n_bad++;
      $display("FAIL sw_exec got %b want 1000011", strb);
    end
    tick();
    mem_ack = 1'b0;
    n_cmp++;
    if (strb !== 7'b1000000 || instr_addr !== 10'd2) begin
      n_bad++;
      $display("FAIL sw_next got %b/%h want 1000000/002",
               strb, instr_addr);
    end
    tick();
    tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL mem_done got %b want 1", done);
    end
  endtask

  task automatic test_branch;
    fill_rom();
    for (int i = 0; i < 7; i++) rom[i] = NOP;
    rom[7] = BR3;
    rom[10'h040] = J3;
    alu_branch = 1'b1;
    lut_target = 10'h040;
    pulse_start();
    repeat (14) tick();
    n_cmp++;
    if (instr_addr !== 10'd7) begin
      n_bad++;
      $display("FAIL nop_walk got %h want 007", instr_addr);
    end
    tick();
    n_cmp++;
    if (r_op !== 4'hC || reg_idx !== 4'd3 || strb !== 7'b1000000) begin
      n_bad++;
      $display("FAIL br_exec got %h/%h/%b want c/3/1000000",
               r_op, reg_idx, strb);
    end
    tick();
    n_cmp++;
    if (instr_addr !== 10'h040) begin
      n_bad++;
      $display("FAIL br_taken got %h want 040", instr_addr);
    end
    lut_target = 10'h123;
    alu_branch = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (instr_addr !== 10'h123) begin
      n_bad++;
      $display("FAIL jump got %h want 123", instr_addr);
    end
    tick();
    tick();
    lut_target = 10'h040;
    pulse_start();
    repeat (16) tick();
    n_cmp++;
    if (instr_addr !== 10'h008) begin
      n_bad++;
      $display("FAIL br_not_taken got %h want 008", instr_addr);
    end
    tick();
    tick();
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL br_done got %b want 1", done);
    end
  endtask

  task automatic test_sc_sticky;
    fill_rom();
    rom[0] = ADD1;
    rom[1] = AND1;
    rom[2] = ADD1;
    rom[3] = SET1;
    alu_sc_out = 1'b1;
    pulse_start();
    tick();
    tick();
    alu_sc_out = 1'b0;
    n_cmp++;
    if (sc_in !== 1'b1) begin
      n_bad++;
      $display("FAIL add_sc got %b want 1", sc_in);
    end
    tick();
    n_cmp++;
    if (strb !== 7'b1010000) begin
      n_bad++;
      $display("FAIL and_exec got %b want 1010000", strb);
    end
    tick();
    tick();
    n_cmp++;
    if (sc_in !== 1'b1) begin
      n_bad++;
      $display("FAIL and_keeps_sc got %b want 1", sc_in);
    end
    tick();
    n_cmp++;
    if (sc_in !== 1'b0) begin
      n_bad++;
      $display("FAIL add2_sc got %b want 0", sc_in);
    end
    tick();
    n_cmp++;
    if (strb !== 7'b1000100) begin
      n_bad++;
      $display("FAIL set_exec got %b want 1000100", strb);
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_wrap_busy;
    fill_rom();
    rom[0] = J3;
    rom[10'h3FF] = NOP;
    lut_target = 10'h3FF;
    start = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++;
    if (instr_addr !== 10'h3FF || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_start got %h/%b want 3ff/1",
               instr_addr, busy);
    end
    rom[0] = HALT;
    tick();
    tick();
    start = 1'b0;
    n_cmp++;
    if (instr_addr !== 10'h000) begin
      n_bad++;
      $display("FAIL pc_wrap got %h want 000", instr_addr);
    end
    tick();
    tick();
    n_cmp++;
    if (strb !== 7'b0100000) begin
      n_bad++;
      $display("FAIL wrap_done got %b want 0100000", strb);
    end
  endtask

  task automatic test_reset_mid_mem;
    fill_rom();
    rom[0] = SW2;
    pulse_start();
    tick();
    tick();
    n_cmp++;
    if (strb !== 7'b1000011) begin
      n_bad++;
      $display("FAIL sw_in_mem got %b want 1000011", strb);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_cmp++;
    if (strb !== 7'b0 || instr_addr !== 10'd0) begin
      n_bad++;
      $display("FAIL mid_mem_reset got %b/%h want 0/000",
               strb, instr_addr);
    end
    rom[0] = ADDI5;
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || instr_addr !== 10'd0) begin
      n_bad++;
      $display("FAIL rerun_fetch got %b/%h want 1/000",
               busy, instr_addr);
    end
    tick();
    n_cmp++;
    if (strb !== 7'b1010000) begin
      n_bad++;
      $display("FAIL rerun_exec got %b want 1010000", strb);
    end
    tick();
    tick();
    tick();
    n_cmp++;
    if (done !== 1'b1 || instr_addr !== 10'd1) begin
      n_bad++;
      $display("FAIL rerun_done got %b/%h want 1/001",
               done, instr_addr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    fill_rom();
    test_reset();
    test_addi_halt();
    test_mem();
    test_branch();
    test_sc_sticky();
    test_wrap_busy();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
